victim_cache_tag_array: RTL and testbench
=========================================

VICTIM_CACHE_TAG_ARRAY -- requirements
Module: victim_cache_tag_array

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of fully-associative entries (power of two, 4..128).
REQ-002 SHALL have parameter TAG_WIDTH, default 26, meaning line-address tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_lookup_valid  input  1  lookup request this cycle.
REQ-006 SHALL have port i_lookup_tag  input  TAG_WIDTH  tag to search.
REQ-007 SHALL have port i_lookup_extract  input  1  on hit, invalidate matched entry (swap into L1).
REQ-008 SHALL have port i_insert_valid  input  1  L1 eviction to store this cycle.
REQ-009 SHALL have port i_insert_tag  input  TAG_WIDTH  tag being inserted.
REQ-010 SHALL have port i_flush  input  1  invalidate all entries.
REQ-011 SHALL have port o_resp_valid  output  1  lookup result valid.
REQ-012 SHALL have port o_match_vec  output  DEPTH  one-hot matched-entry vector, all-zero on miss; drives the one-hot-to-index encoder.
REQ-013 SHALL have port o_hit  output  1  OR of o_match_vec.
REQ-014 SHALL have port o_evict_valid  output  1  insert displaced a valid entry.
REQ-015 SHALL have port o_evict_tag  output  TAG_WIDTH  tag of displaced entry.
REQ-016 SHALL have port o_count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL hold per entry a valid bit and a TAG_WIDTH tag register, plus a round-robin pointer of clog2(DEPTH) bits.
REQ-018 SHALL compare i_lookup_tag against all valid entries in cycle N using pre-update state, and present o_resp_valid=1, o_match_vec, o_hit registered in cycle N+1 (latency 1, one request per cycle, no backpressure).
REQ-019 SHALL guarantee o_match_vec has at most one bit set under all input sequences (invariant: no two valid entries hold equal tags).
REQ-020 SHALL, on lookup hit with i_lookup_extract=1, clear the matched valid bit at the end of cycle N; on miss, extract has no effect.
REQ-021 SHALL choose the insert slot as: existing valid entry with equal tag (overwrite in place, no eviction, pointer unchanged); else lowest-index invalid entry (pointer unchanged); else the entry at the pointer, which then advances by one, wrapping DEPTH-1 -> 0.
REQ-022 SHALL, when the insert overwrites a valid entry with a different tag, pulse o_evict_valid=1 with o_evict_tag=old tag in cycle N+1 for exactly one cycle.
REQ-023 SHALL, when insert and extract occur in the same cycle and target the same slot, leave the slot valid with i_insert_tag (insert wins); the slot choice uses pre-update state.
REQ-024 SHALL treat an insert whose tag equals a same-cycle extracted hit tag as overwrite-in-place; the entry remains valid.
REQ-025 SHALL, on i_flush, clear all valid bits and the pointer at end of cycle; flush overrides same-cycle insert and extract; a same-cycle lookup still responds from pre-flush state.
REQ-026 SHALL update o_count registered, reflecting state after each edge, saturating never (range 0..DEPTH).
REQ-027 SHALL drive o_match_vec and o_hit to zero in any cycle where o_resp_valid=0.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, clear all valid bits, pointer=0, o_resp_valid=0, o_match_vec=0, o_hit=0, o_evict_valid=0, o_evict_tag=0, o_count=0; tag storage need not be cleared.
REQ-029 SHALL give rst priority over flush, insert, lookup; a lookup issued during the reset cycle produces no response.

Verification
REQ-030 SHALL test: reset, insert tags 0x10,0x11,0x12 -> o_count=3; lookup 0x11 -> next cycle o_hit=1, o_match_vec=0x0002.
REQ-031 SHALL test: fill 16 entries tags 0x100..0x10F, insert 0x200 -> slot 0 replaced, o_evict_valid=1, o_evict_tag=0x100, pointer=1; insert 0x201 -> evicts 0x101.
REQ-032 SHALL test: lookup 0x105 with extract -> o_hit=1, o_count drops by 1; repeat lookup -> o_hit=0, o_match_vec=0; next insert fills slot 5, no eviction.
REQ-033 SHALL test: same-cycle extract of 0x107 and insert of 0x300 with table full (pointer not at 7) -> slot 7 holds 0x300, pointer slot untouched, no eviction.
REQ-034 SHALL test: duplicate insert of resident tag 0x10A -> no eviction, o_count unchanged, later lookup one-hot.
REQ-035 SHALL test: flush with concurrent insert and lookup of resident tag -> lookup hits next cycle, o_count=0, pointer=0, insert discarded.

Source files
------------

// File: rtl/victim_cache_tag_array_if.sv
// Victim cache tag array bus: lookup, insert and flush requests toward the
// array, and the registered lookup/eviction/occupancy results back.
interface victim_cache_tag_array_if #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = 26
);
  logic                      i_lookup_valid;
  logic [TAG_WIDTH-1:0]      i_lookup_tag;
  logic                      i_lookup_extract;
  logic                      i_insert_valid;
  logic [TAG_WIDTH-1:0]      i_insert_tag;
  logic                      i_flush;
  logic                      o_resp_valid;
  logic [DEPTH-1:0]          o_match_vec;
  logic                      o_hit;
  logic                      o_evict_valid;
  logic [TAG_WIDTH-1:0]      o_evict_tag;
  logic [$clog2(DEPTH):0]    o_count;

  modport master (
    output i_lookup_valid, i_lookup_tag, i_lookup_extract,
    output i_insert_valid, i_insert_tag, i_flush,
    input  o_resp_valid, o_match_vec, o_hit,
    input  o_evict_valid, o_evict_tag, o_count
  );

  modport slave (
    input  i_lookup_valid, i_lookup_tag, i_lookup_extract,
    input  i_insert_valid, i_insert_tag, i_flush,
    output o_resp_valid, o_match_vec, o_hit,
    output o_evict_valid, o_evict_tag, o_count
  );
endinterface

// File: rtl/victim_cache_tag_array.sv
// Fully-associative victim cache tag array. Holds lines evicted from L1,
// answers one lookup per cycle with a one-hot match vector one cycle later,
// and reports the tag of any valid line displaced by an insert.
module victim_cache_tag_array #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = 26
) (
  input logic                   clk,
  input logic                   rst,
  victim_cache_tag_array_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]     valid;
  logic [TAG_WIDTH-1:0] tags [DEPTH];
  logic [PW-1:0]        ptr;

  logic                 resp_valid;
  logic [DEPTH-1:0]     match_vec;
  logic                 hit;
  logic                 evict_valid;
  logic [TAG_WIDTH-1:0] evict_tag;
  logic [CW-1:0]        count;

  logic [DEPTH-1:0]     lookup_match;
  logic [DEPTH-1:0]     extract_vec;
  logic [DEPTH-1:0]     dup_vec;
  logic [DEPTH-1:0]     free_vec;
  logic [PW-1:0]        ins_slot;
  logic                 ins_dup;
  logic                 ins_free;
  logic                 ins_replace;
  logic                 do_insert;
  logic [DEPTH-1:0]     next_valid;
  logic [CW-1:0]        next_count;

  // Parallel tag compare of lookup and insert tags against the pre-update state
  always_comb begin
    lookup_match = '0;
    dup_vec      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_match[i] = bus.i_lookup_valid && valid[i] && (tags[i] == bus.i_lookup_tag);
      dup_vec[i]      = valid[i] && (tags[i] == bus.i_insert_tag);
    end
    extract_vec = bus.i_lookup_extract ? lookup_match : '0;
    free_vec    = ~valid | extract_vec;
  end

  // Insert slot choice: resident equal tag, else lowest free slot (a slot being
  // extracted this cycle counts as free so a swap never evicts), else pointer
  always_comb begin
    ins_slot    = ptr;
    ins_dup     = 1'b0;
    ins_free    = 1'b0;
    ins_replace = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dup_vec[i]) begin
        ins_slot = PW'(i);
        ins_dup  = 1'b1;
      end
    end
    if (!ins_dup) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (free_vec[i]) begin
          ins_slot = PW'(i);
          ins_free = 1'b1;
        end
      end
    end
    if (!ins_dup && !ins_free) begin
      ins_slot    = ptr;
      ins_replace = 1'b1;
    end
  end

  // Next valid vector and its population count; flush wipes everything
  always_comb begin
    do_insert  = bus.i_insert_valid && !bus.i_flush;
    next_valid = valid & ~extract_vec;
    if (do_insert) begin
      next_valid[ins_slot] = 1'b1;
    end
    if (bus.i_flush) begin
      next_valid = '0;
    end
    next_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      next_count = next_count + CW'(next_valid[i]);
    end
  end

  // Control state and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      ptr         <= '0;
      resp_valid  <= 1'b0;
      match_vec   <= '0;
      hit         <= 1'b0;
      evict_valid <= 1'b0;
      evict_tag   <= '0;
      count       <= '0;
    end else begin
      valid      <= next_valid;
      resp_valid <= bus.i_lookup_valid;
      match_vec  <= lookup_match;
      hit        <= |lookup_match;
      count      <= next_count;
      if (bus.i_flush) begin
        ptr <= '0;
      end else if (do_insert && ins_replace) begin
        ptr <= ptr + 1'b1;
      end
      if (do_insert && ins_replace && valid[ins_slot]) begin
        evict_valid <= 1'b1;
        evict_tag   <= tags[ins_slot];
      end else begin
        evict_valid <= 1'b0;
        evict_tag   <= '0;
      end
    end
  end

  // Tag storage needs no reset; entries only matter once their valid bit is set
  always_ff @(posedge clk) begin
    if (!rst && do_insert) begin
      tags[ins_slot] <= bus.i_insert_tag;
    end
  end

  assign bus.o_resp_valid  = resp_valid;
  assign bus.o_match_vec   = match_vec;
  assign bus.o_hit         = hit;
  assign bus.o_evict_valid = evict_valid;
  assign bus.o_evict_tag   = evict_tag;
  assign bus.o_count       = count;

endmodule

// File: tb/tb_victim_cache_tag_array.sv
// Directed testbench for victim_cache_tag_array (DEPTH=16, TAG_WIDTH=26).
module tb_victim_cache_tag_array;

  localparam int DEPTH     = 16;
  localparam int TAG_WIDTH = 26;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  victim_cache_tag_array_if #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  victim_cache_tag_array #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.i_lookup_valid   = 1'b0;
    bus.i_lookup_tag     = '0;
    bus.i_lookup_extract = 1'b0;
    bus.i_insert_valid   = 1'b0;
    bus.i_insert_tag     = '0;
    bus.i_flush          = 1'b0;
  endtask

  // Advance one edge with current inputs, then release them and settle
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h10;
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h10;
    @(posedge clk);
    #1;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h10;
    step();
    rst = 1'b0;
    checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %0h want 0", bus.o_resp_valid); end
    checks++; if (bus.o_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %0h want 0", bus.o_hit); end
    checks++; if (bus.o_match_vec !== 16'h0) begin errors++; $display("[TB] FAIL reset_match: got %h want 0000", bus.o_match_vec); end
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_evict_valid: got %0h want 0", bus.o_evict_valid); end
    checks++; if (bus.o_evict_tag !== 26'h0) begin errors++; $display("[TB] FAIL reset_evict_tag: got %h want 0", bus.o_evict_tag); end
    checks++; if (bus.o_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.o_count); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      bus.i_insert_valid = 1'b1;
      bus.i_insert_tag   = 26'h10 + 26'(i);
      step();
    end
    checks++; if (bus.o_count !== 5'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d want 3", bus.o_count); end
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_evict: got %0h want 0", bus.o_evict_valid); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h11;
    step();
    checks++; if (bus.o_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_resp_valid: got %0h want 1", bus.o_resp_valid); end
    checks++; if (bus.o_hit !== 1'b1) begin errors++; $display("[TB] FAIL basic_hit: got %0h want 1", bus.o_hit); end
    checks++; if (bus.o_match_vec !== 16'h0002) begin errors++; $display("[TB] FAIL basic_match: got %h want 0002", bus.o_match_vec); end
    step();
    checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_resp_valid: got %0h want 0", bus.o_resp_valid); end
    checks++; if (bus.o_match_vec !== 16'h0 || bus.o_hit !== 1'b0) begin errors++; $display("[TB] FAIL idle_match_zero: got %h/%0h want 0000/0", bus.o_match_vec, bus.o_hit); end
  endtask

  task automatic test_fill_evict();
    bus.i_flush = 1'b1;
    step();
    checks++; if (bus.o_count !== 5'd0) begin errors++; $display("[TB] FAIL fill_flush_count: got %0d want 0", bus.o_count); end
    for (int i = 0; i < 16; i++) begin
      bus.i_insert_valid = 1'b1;
      bus.i_insert_tag   = 26'h100 + 26'(i);
      step();
      checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_evict_%0d: got %0h want 0", i, bus.o_evict_valid); end
    end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL fill_count: got %0d want 16", bus.o_count); end
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h200;
    step();
    checks++; if (bus.o_evict_valid !== 1'b1) begin errors++; $display("[TB] FAIL evict0_valid: got %0h want 1", bus.o_evict_valid); end
    checks++; if (bus.o_evict_tag !== 26'h100) begin errors++; $display("[TB] FAIL evict0_tag: got %h want 100", bus.o_evict_tag); end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL evict0_count: got %0d want 16", bus.o_count); end
    step();
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL evict_pulse_width: got %0h want 0", bus.o_evict_valid); end
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h201;
    step();
    checks++; if (bus.o_evict_valid !== 1'b1 || bus.o_evict_tag !== 26'h101) begin errors++; $display("[TB] FAIL evict1: got %0h/%h want 1/101", bus.o_evict_valid, bus.o_evict_tag); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h200;
    step();
    checks++; if (bus.o_match_vec !== 16'h0001) begin errors++; $display("[TB] FAIL lookup_200: got %h want 0001", bus.o_match_vec); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h100;
    step();
    checks++; if (bus.o_hit !== 1'b0 || bus.o_match_vec !== 16'h0) begin errors++; $display("[TB] FAIL lookup_evicted_100: got %0h/%h want 0/0000", bus.o_hit, bus.o_match_vec); end
  endtask

  task automatic test_extract();
    bus.i_lookup_valid   = 1'b1;
    bus.i_lookup_tag     = 26'h105;
    bus.i_lookup_extract = 1'b1;
    step();
    checks++; if (bus.o_hit !== 1'b1 || bus.o_match_vec !== 16'h0020) begin errors++; $display("[TB] FAIL extract_hit: got %0h/%h want 1/0020", bus.o_hit, bus.o_match_vec); end
    checks++; if (bus.o_count !== 5'd15) begin errors++; $display("[TB] FAIL extract_count: got %0d want 15", bus.o_count); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h105;
    step();
    checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_hit !== 1'b0 || bus.o_match_vec !== 16'h0) begin errors++; $display("[TB] FAIL extract_gone: got %0h/%0h/%h want 1/0/0000", bus.o_resp_valid, bus.o_hit, bus.o_match_vec); end
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h202;
    step();
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL refill_no_evict: got %0h want 0", bus.o_evict_valid); end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL refill_count: got %0d want 16", bus.o_count); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h202;
    step();
    checks++; if (bus.o_match_vec !== 16'h0020) begin errors++; $display("[TB] FAIL refill_slot5: got %h want 0020", bus.o_match_vec); end
  endtask

  task automatic test_same_cycle();
    bus.i_lookup_valid   = 1'b1;
    bus.i_lookup_tag     = 26'h107;
    bus.i_lookup_extract = 1'b1;
    bus.i_insert_valid   = 1'b1;
    bus.i_insert_tag     = 26'h300;
    step();
    checks++; if (bus.o_hit !== 1'b1 || bus.o_match_vec !== 16'h0080) begin errors++; $display("[TB] FAIL swap_hit: got %0h/%h want 1/0080", bus.o_hit, bus.o_match_vec); end
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL swap_no_evict: got %0h want 0", bus.o_evict_valid); end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL swap_count: got %0d want 16", bus.o_count); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h300;
    step();
    checks++; if (bus.o_match_vec !== 16'h0080) begin errors++; $display("[TB] FAIL swap_slot7: got %h want 0080", bus.o_match_vec); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h102;
    step();
    checks++; if (bus.o_match_vec !== 16'h0004) begin errors++; $display("[TB] FAIL swap_ptr_slot_kept: got %h want 0004", bus.o_match_vec); end
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h301;
    step();
    checks++; if (bus.o_evict_valid !== 1'b1 || bus.o_evict_tag !== 26'h102) begin errors++; $display("[TB] FAIL swap_ptr_unchanged: got %0h/%h want 1/102", bus.o_evict_valid, bus.o_evict_tag); end
  endtask

  task automatic test_duplicate();
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h10A;
    step();
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL dup_no_evict: got %0h want 0", bus.o_evict_valid); end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL dup_count: got %0d want 16", bus.o_count); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h10A;
    step();
    checks++; if (bus.o_hit !== 1'b1 || bus.o_match_vec !== 16'h0400) begin errors++; $display("[TB] FAIL dup_onehot: got %0h/%h want 1/0400", bus.o_hit, bus.o_match_vec); end
    bus.i_lookup_valid   = 1'b1;
    bus.i_lookup_tag     = 26'h10B;
    bus.i_lookup_extract = 1'b1;
    bus.i_insert_valid   = 1'b1;
    bus.i_insert_tag     = 26'h10B;
    step();
    checks++; if (bus.o_match_vec !== 16'h0800 || bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL dup_extract_same: got %h/%0h want 0800/0", bus.o_match_vec, bus.o_evict_valid); end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL dup_extract_count: got %0d want 16", bus.o_count); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h10B;
    step();
    checks++; if (bus.o_match_vec !== 16'h0800) begin errors++; $display("[TB] FAIL dup_extract_kept: got %h want 0800", bus.o_match_vec); end
  endtask

  task automatic test_back_to_back();
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h200;
    step();
    checks++; if (bus.o_match_vec !== 16'h0001) begin errors++; $display("[TB] FAIL b2b_0: got %h want 0001", bus.o_match_vec); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h106;
    step();
    checks++; if (bus.o_match_vec !== 16'h0040) begin errors++; $display("[TB] FAIL b2b_1: got %h want 0040", bus.o_match_vec); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h999;
    step();
    checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_hit !== 1'b0 || bus.o_match_vec !== 16'h0) begin errors++; $display("[TB] FAIL b2b_miss: got %0h/%0h/%h want 1/0/0000", bus.o_resp_valid, bus.o_hit, bus.o_match_vec); end
  endtask

  task automatic test_flush();
    bus.i_flush        = 1'b1;
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h400;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h10C;
    step();
    checks++; if (bus.o_hit !== 1'b1 || bus.o_match_vec !== 16'h1000) begin errors++; $display("[TB] FAIL flush_lookup: got %0h/%h want 1/1000", bus.o_hit, bus.o_match_vec); end
    checks++; if (bus.o_count !== 5'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d want 0", bus.o_count); end
    checks++; if (bus.o_evict_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_evict: got %0h want 0", bus.o_evict_valid); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_tag   = 26'h400;
    step();
    checks++; if (bus.o_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush_insert_dropped: got %0h want 0", bus.o_hit); end
    for (int i = 0; i < 16; i++) begin
      bus.i_insert_valid = 1'b1;
      bus.i_insert_tag   = 26'h500 + 26'(i);
      step();
    end
    checks++; if (bus.o_count !== 5'd16) begin errors++; $display("[TB] FAIL flush_refill_count: got %0d want 16", bus.o_count); end
    bus.i_insert_valid = 1'b1;
    bus.i_insert_tag   = 26'h600;
    step();
    checks++; if (bus.o_evict_valid !== 1'b1 || bus.o_evict_tag !== 26'h500) begin errors++; $display("[TB] FAIL flush_ptr_zero: got %0h/%h want 1/500", bus.o_evict_valid, bus.o_evict_tag); end
  endtask

  // Scenario sequence; state carries over from one scenario to the next
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_fill_evict();
    test_extract();
    test_same_cycle();
    test_duplicate();
    test_back_to_back();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
